// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 field widths, bias and the converter state encoding.
package fp16_pkg;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_BIAS   = 15;
  localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;
  localparam int MAX_RSHIFT  = 13;
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
endpackage

// File: rtl/fp16_to_fixed_serial_if.sv
// fp16_to_fixed_serial_if: operand handshake and result bus of the FP16-to-fixed converter.
interface fp16_to_fixed_serial_if #(parameter int OUT_W = 32);
  logic             i_valid;
  logic             o_ready;
  logic [15:0]      i_a;
  logic [OUT_W-1:0] o_res;
  logic             o_res_vld;
  logic             o_overflow;
  logic             o_nan;
  logic             o_inexact;
  modport master (output i_valid, i_a, input o_ready, o_res, o_res_vld, o_overflow, o_nan, o_inexact);
  modport slave  (input i_valid, i_a, output o_ready, o_res, o_res_vld, o_overflow, o_nan, o_inexact);
endinterface

// File: rtl/fp16_unpack.sv
// fp16_unpack: classifies an FP16 operand and yields its significand and effective exponent.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]            a_i,
  output logic                   sign_o,
  output logic                   is_zero_o,
  output logic                   is_sub_o,
  output logic                   is_inf_o,
  output logic                   is_nan_o,
  output logic [FP16_MANT_W:0]   sig_o,
  output logic [FP16_EXP_W-1:0]  e_eff_o
);
  logic [FP16_EXP_W-1:0]  exp_f;
  logic [FP16_MANT_W-1:0] mant_f;
  always_comb begin
    exp_f     = a_i[FP16_MANT_W +: FP16_EXP_W];
    mant_f    = a_i[FP16_MANT_W-1:0];
    sign_o    = a_i[15];
    is_zero_o = (exp_f == '0) && (mant_f == '0);
    is_sub_o  = (exp_f == '0) && (mant_f != '0);
    is_inf_o  = (exp_f == FP16_EXP_MAX) && (mant_f == '0);
    is_nan_o  = (exp_f == FP16_EXP_MAX) && (mant_f != '0);
    sig_o     = {exp_f != '0, mant_f};
    e_eff_o   = (exp_f == '0) ? FP16_EXP_W'(1) : exp_f;
  end
endmodule

// File: rtl/fp16_to_fixed_serial.sv
// fp16_to_fixed_serial: iterative FP16 -> signed fixed-point converter, one shift bit per cycle.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp16_to_fixed_serial
  import fp16_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  fp16_to_fixed_serial_if.slave  bus
);
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [OUT_W-1:0]      mag_q, mag_d, res_q, res_d, mag_r;
  logic                  sign_q, sign_d, left_q, left_d, guard_q, guard_d, sticky_q, sticky_d;
  logic                  nan_q, nan_d, sat_q, sat_d;
  logic                  vld_q, vld_d, ovf_q, ovf_d, onan_q, onan_d, inx_q, inx_d;
  logic                  u_sign, u_zero, u_sub, u_inf, u_nan, inc, rnd_ovf;
  logic [FP16_MANT_W:0]  u_sig;
  logic [FP16_EXP_W-1:0] u_eff;
  int                    sh, top_bit;

  fp16_unpack u_unpack (
    .a_i(bus.i_a), .sign_o(u_sign), .is_zero_o(u_zero), .is_sub_o(u_sub),
    .is_inf_o(u_inf), .is_nan_o(u_nan), .sig_o(u_sig), .e_eff_o(u_eff)
  );

`ifdef ROUND_NEAREST_EN
  assign inc = guard_q & (sticky_q | mag_q[0]);
`else
  assign inc = 1'b0;
`endif

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_res      = res_q;
  assign bus.o_res_vld  = vld_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_nan      = onan_q;
  assign bus.o_inexact  = inx_q;

  always_comb begin
    sh       = int'(u_eff) - (FP16_BIAS + FP16_MANT_W) + FRAC_W;
    top_bit  = int'(u_eff) - FP16_BIAS + FRAC_W;
    mag_r    = mag_q + OUT_W'(inc);
    rnd_ovf  = mag_r[OUT_W-1];
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_d    = mag_q;
    sign_d   = sign_q;
    left_d   = left_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    nan_d    = nan_q;
    sat_d    = sat_q;
    vld_d    = 1'b0;
    res_d    = res_q;
    ovf_d    = ovf_q;
    onan_d   = onan_q;
    inx_d    = inx_q;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        sign_d   = u_sign;
        nan_d    = u_nan;
        // Subnormals and zero can never reach the saturation threshold.
        sat_d    = u_inf | (!u_zero && !u_sub && !u_nan && !u_inf && top_bit >= OUT_W - 1);
        mag_d    = OUT_W'(u_sig);
        left_d   = sh > 0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        cnt_d    = sh > 0 ? 6'(sh) : 6'((-sh > MAX_RSHIFT) ? MAX_RSHIFT : -sh);
        state_d  = (u_zero || u_nan || sat_d || sh == 0) ? FIN : SHIFT;
      end
      SHIFT: begin
        mag_d    = left_q ? mag_q << 1 : mag_q >> 1;
        guard_d  = left_q ? guard_q : mag_q[0];
        sticky_d = left_q ? sticky_q : sticky_q | guard_q;
        cnt_d    = cnt_q - 6'd1;
        state_d  = (cnt_q == 6'd1) ? FIN : SHIFT;
      end
      FIN: begin
        state_d = IDLE;
        vld_d   = 1'b1;
        onan_d  = nan_q;
        ovf_d   = !nan_q && (sat_q || rnd_ovf);
        inx_d   = !nan_q && !sat_q && (guard_q || sticky_q);
        res_d   = nan_q ? '0 : (sat_q || rnd_ovf) ? (sign_q ? NEG_MAX : POS_MAX) : sign_q ? -mag_r : mag_r;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      nan_q    <= 1'b0;
      sat_q    <= 1'b0;
      vld_q    <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      onan_q   <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      left_q   <= left_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      nan_q    <= nan_d;
      sat_q    <= sat_d;
      vld_q    <= vld_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      onan_q   <= onan_d;
      inx_q    <= inx_d;
    end
  end
endmodule

// File: tb/tb_fp16_to_fixed_serial.sv
// tb_fp16_to_fixed_serial: directed checks of the FP16 -> fixed converter at OUT_W=32 and OUT_W=16.
module tb_fp16_to_fixed_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  fp16_to_fixed_serial_if #(.OUT_W(32)) b32();
  fp16_to_fixed_serial_if #(.OUT_W(16)) b16();

  fp16_to_fixed_serial #(.OUT_W(32), .FRAC_W(0)) dut   (.clk(clk), .rst_n(rst_n), .bus(b32));
  fp16_to_fixed_serial #(.OUT_W(16), .FRAC_W(0)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  always #5 clk = ~clk;

  // Accept edge is T; cyc counts edges after T until o_res_vld is seen, so cyc = N+1.
  task automatic run32(input logic [15:0] a, output logic [31:0] res,
                       output logic ovf, output logic nan, output logic inx, output int cyc);
    b32.i_valid = 1'b1;
    b32.i_a = a;
    @(posedge clk); #1;
    b32.i_valid = 1'b0;
    b32.i_a = 16'h7E00;
    cyc = 0;
    while (!b32.o_res_vld && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!b32.o_res_vld) begin
      bad++;
      $display("FAIL timeout32 a=%h: o_res_vld=%b want 1 within 100 cycles", a, b32.o_res_vld);
    end
    res = b32.o_res; ovf = b32.o_overflow; nan = b32.o_nan; inx = b32.o_inexact;
  endtask

  task automatic run16(input logic [15:0] a, output logic [15:0] res, output logic ovf, output int cyc);
    b16.i_valid = 1'b1;
    b16.i_a = a;
    @(posedge clk); #1;
    b16.i_valid = 1'b0;
    b16.i_a = 16'h0000;
    cyc = 0;
    while (!b16.o_res_vld && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (!b16.o_res_vld) begin
      bad++;
      $display("FAIL timeout16 a=%h: o_res_vld=%b want 1 within 100 cycles", a, b16.o_res_vld);
    end
    res = b16.o_res; ovf = b16.o_overflow;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (b32.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", b32.o_ready); end
    total++; if (b32.o_res_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", b32.o_res_vld); end
    total++; if (b32.o_res !== 32'h0) begin bad++; $display("FAIL rst_res got=%h want=0", b32.o_res); end
    total++; if ({b32.o_overflow, b32.o_nan, b32.o_inexact} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b want=000", {b32.o_overflow, b32.o_nan, b32.o_inexact}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] r; logic o, n, x; int c;
    run32(16'h3C00, r, o, n, x, c);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL one_res got=%h want=00000001", r); end
    total++; if (c !== 11) begin bad++; $display("FAIL one_latency got=%0d want=11", c); end
    total++; if ({o, n, x} !== 3'b000) begin bad++; $display("FAIL one_flags got=%b want=000", {o, n, x}); end
    run32(16'hC500, r, o, n, x, c);
    total++; if (r !== 32'hFFFFFFFB) begin bad++; $display("FAIL neg5_res got=%h want=fffffffb", r); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL neg5_inexact got=%b want=0", x); end
    run32(16'h7BFF, r, o, n, x, c);
    total++; if (r !== 32'h0000FFE0) begin bad++; $display("FAIL max_res got=%h want=0000ffe0", r); end
    total++; if (c !== 6) begin bad++; $display("FAIL max_latency got=%0d want=6", c); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL max_ovf got=%b want=0", o); end
  endtask

  task automatic test_special();
    logic [31:0] r; logic [15:0] r16; logic o, n, x; int c;
    run32(16'h7C00, r, o, n, x, c);
    total++; if (r !== 32'h7FFFFFFF) begin bad++; $display("FAIL pinf_res got=%h want=7fffffff", r); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL pinf_ovf got=%b want=1", o); end
    total++; if (c !== 1) begin bad++; $display("FAIL pinf_latency got=%0d want=1", c); end
    run32(16'hFC00, r, o, n, x, c);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL ninf_res got=%h want=80000000", r); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL ninf_ovf got=%b want=1", o); end
    run32(16'h7E00, r, o, n, x, c);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL nan_res got=%h want=0", r); end
    total++; if ({o, n} !== 2'b01) begin bad++; $display("FAIL nan_flags got=%b want=01", {o, n}); end
    run32(16'h8000, r, o, n, x, c);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL nzero_res got=%h want=0", r); end
    total++; if (c !== 1) begin bad++; $display("FAIL nzero_latency got=%0d want=1", c); end
    total++; if ({o, n, x} !== 3'b000) begin bad++; $display("FAIL nzero_flags got=%b want=000", {o, n, x}); end
    run32(16'h0001, r, o, n, x, c);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL sub_res got=%h want=0", r); end
    total++; if (x !== 1'b1) begin bad++; $display("FAIL sub_inexact got=%b want=1", x); end
    total++; if (c !== 14) begin bad++; $display("FAIL sub_latency got=%0d want=14", c); end
    run16(16'h7800, r16, o, c);
    total++; if (r16 !== 16'h7FFF) begin bad++; $display("FAIL w16_pos_res got=%h want=7fff", r16); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL w16_pos_ovf got=%b want=1", o); end
    run16(16'hF800, r16, o, c);
    total++; if (r16 !== 16'h8000) begin bad++; $display("FAIL w16_neg_res got=%h want=8000", r16); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL w16_neg_ovf got=%b want=1", o); end
    run16(16'h7400, r16, o, c);
    total++; if (r16 !== 16'h4000) begin bad++; $display("FAIL w16_edge_res got=%h want=4000", r16); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL w16_edge_ovf got=%b want=0", o); end
  endtask

  task automatic test_round();
    logic [31:0] r; logic o, n, x; int c;
    logic [31:0] e15, e25;
`ifdef ROUND_NEAREST_EN
    e15 = 32'd2; e25 = 32'd2;
`else
    e15 = 32'd1; e25 = 32'd2;
`endif
    run32(16'h3E00, r, o, n, x, c);
    total++; if (r !== e15) begin bad++; $display("FAIL r1p5_res got=%h want=%h", r, e15); end
    total++; if (x !== 1'b1) begin bad++; $display("FAIL r1p5_inexact got=%b want=1", x); end
    run32(16'h4100, r, o, n, x, c);
    total++; if (r !== e25) begin bad++; $display("FAIL r2p5_res got=%h want=%h", r, e25); end
    total++; if (x !== 1'b1) begin bad++; $display("FAIL r2p5_inexact got=%b want=1", x); end
    run32(16'h3D00, r, o, n, x, c);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL r1p25_res got=%h want=00000001", r); end
    total++; if (x !== 1'b1) begin bad++; $display("FAIL r1p25_inexact got=%b want=1", x); end
    run32(16'hBE00, r, o, n, x, c);
    total++; if (r !== -e15) begin bad++; $display("FAIL rn1p5_res got=%h want=%h", r, -e15); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic o, n, x; int c;
    run32(16'h4000, r, o, n, x, c);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL b2b_first got=%h want=00000002", r); end
    total++; if (b32.o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_in_vld got=%b want=1", b32.o_ready); end
    run32(16'h4200, r, o, n, x, c);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL b2b_second got=%h want=00000003", r); end
    total++; if (c !== 10) begin bad++; $display("FAIL b2b_latency got=%0d want=10", c); end
  endtask

  task automatic test_hold();
    int c, n;
    b32.i_valid = 1'b1;
    b32.i_a = 16'h4000;
    @(posedge clk); #1;
    b32.i_a = 16'h4200;
    c = 0;
    while (!b32.o_res_vld && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    b32.i_valid = 1'b0;
    total++; if (b32.o_res !== 32'd2) begin bad++; $display("FAIL hold_res got=%h want=00000002", b32.o_res); end
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b32.o_res_vld) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL hold_extra_vld got=%0d want=0", n); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; logic o, nn, x; int c, n;
    b32.i_valid = 1'b1;
    b32.i_a = 16'h3C00;
    @(posedge clk); #1;
    b32.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (b32.o_ready !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", b32.o_ready); end
    rst_n = 1'b0;
    #2;
    total++; if (b32.o_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", b32.o_ready); end
    total++; if (b32.o_res !== 32'h0) begin bad++; $display("FAIL abort_res got=%h want=0", b32.o_res); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b32.o_res_vld) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL abort_vld got=%0d want=0", n); end
    run32(16'h4000, r, o, nn, x, c);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL abort_next got=%h want=00000002", r); end
  endtask

  initial begin
    b32.i_valid = 1'b0; b32.i_a = 16'h0;
    b16.i_valid = 1'b0; b16.i_a = 16'h0;
    test_reset();
    test_basic();
    test_special();
    test_round();
    test_back_to_back();
    test_hold();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
